// File: rtl/midi_message_sequencer.sv
// midi_message_sequencer
// Converts one latched note event into a 3-byte MIDI channel message
// (status, note, velocity) and streams it onto a valid/ready byte interface.
// After the last byte is handed off, or the note is rejected, it returns a
// one-cycle ack to the input buffer.
// Optional build macro: MIDI_RUNNING_STATUS_EN. When it is defined, the
// status byte is omitted if it matches the last status byte sent.
module midi_message_sequencer #(
  parameter int         BASE_NOTE         = 48,
  parameter logic [6:0] NOTE_ON_VELOCITY  = 7'h64,
  parameter logic [6:0] NOTE_OFF_VELOCITY = 7'h40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       msg_valid,
  input  logic       msg_note_on,
  input  logic [3:0] msg_note,
  input  logic [1:0] msg_octave,
  input  logic [3:0] msg_channel,
  output logic       msg_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       note_error,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, STATUS, NOTE, VEL, ACK} state_t;

  function automatic logic [7:0] status_byte(input logic on, input logic [3:0] ch);
    return {1'b1, 2'b00, on, ch};
  endfunction

  function automatic logic [7:0] note_byte(input logic [3:0] n, input logic [1:0] oct);
    logic [7:0] s;
    s = 8'(BASE_NOTE) + 8'(oct) * 8'd12 + 8'(n);
    return {1'b0, s[6:0]};
  endfunction

  function automatic logic [7:0] vel_byte(input logic on);
    return {1'b0, on ? NOTE_ON_VELOCITY : NOTE_OFF_VELOCITY};
  endfunction

  state_t     state_q, state_d;
  logic       on_q, on_d;
  logic [3:0] note_q, note_d;
  logic [1:0] octave_q, octave_d;
  logic [3:0] channel_q, channel_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       msg_ack_q, msg_ack_d;
  logic       note_error_q, note_error_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;
  // Set on a rejected note so ACK holds for one extra cycle before acking.
  logic       rej_q, rej_d;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;
  logic       last_vld_q, last_vld_d;
`endif

  logic [7:0] in_status;
  logic       skip_status;

  // Next-state, byte sequencing and pulse outputs
  always_comb begin
    state_d      = state_q;
    on_d         = on_q;
    note_d       = note_q;
    octave_d     = octave_q;
    channel_d    = channel_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    msg_ack_d    = 1'b0;
    note_error_d = 1'b0;
    overrun_d    = 1'b0;
    rej_d        = rej_q;
`ifdef MIDI_RUNNING_STATUS_EN
    last_status_d = last_status_q;
    last_vld_d    = last_vld_q;
`endif
    in_status   = status_byte(msg_note_on, msg_channel);
    skip_status = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    skip_status = last_vld_q && (in_status == last_status_q);
`endif

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          if (msg_note < 4'd12) begin
            on_d       = msg_note_on;
            note_d     = msg_note;
            octave_d   = msg_octave;
            channel_d  = msg_channel;
            tx_valid_d = 1'b1;
            if (skip_status) begin
              state_d   = NOTE;
              tx_data_d = note_byte(msg_note, msg_octave);
            end else begin
              state_d   = STATUS;
              tx_data_d = in_status;
            end
          end else begin
            state_d      = ACK;
            rej_d        = 1'b1;
            note_error_d = 1'b1;
          end
        end
      end
      STATUS: begin
        if (tx_ready) begin
          state_d   = NOTE;
          tx_data_d = note_byte(note_q, octave_q);
`ifdef MIDI_RUNNING_STATUS_EN
          last_status_d = tx_data_q;
          last_vld_d    = 1'b1;
`endif
        end
      end
      NOTE: begin
        if (tx_ready) begin
          state_d   = VEL;
          tx_data_d = vel_byte(on_q);
        end
      end
      VEL: begin
        if (tx_ready) begin
          state_d    = ACK;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          msg_ack_d  = 1'b1;
        end
      end
      ACK: begin
        if (rej_q) begin
          rej_d     = 1'b0;
          msg_ack_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (msg_valid && (state_q != IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      on_q         <= 1'b0;
      note_q       <= 4'h0;
      octave_q     <= 2'h0;
      channel_q    <= 4'h0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      msg_ack_q    <= 1'b0;
      note_error_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      on_q         <= on_d;
      note_q       <= note_d;
      octave_q     <= octave_d;
      channel_q    <= channel_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      msg_ack_q    <= msg_ack_d;
      note_error_q <= note_error_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      rej_q        <= rej_d;
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // Running-status memory; only reset invalidates it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_status_q <= 8'h00;
      last_vld_q    <= 1'b0;
    end else begin
      last_status_q <= last_status_d;
      last_vld_q    <= last_vld_d;
    end
  end
`endif

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign msg_ack    = msg_ack_q;
  assign note_error = note_error_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: doc/midi_message_sequencer.md
Name: midi_message_sequencer

Overview:
- Sits between midi_status_input_buffer and the MIDI UART transmitter.
- Latches one note event offered by the buffer and converts it to a 3-byte MIDI channel message: status, note number, velocity.
- Sequences the bytes onto a valid/ready byte stream.
- Returns a single-cycle ack to the buffer when the message has been fully handed off, or rejected.

Parameters:
- BASE_NOTE, 48, MIDI note number for note 0 / octave 0; BASE_NOTE + 47 must be ≤ 127.
- NOTE_ON_VELOCITY, 7'h64, velocity byte sent with note-on.
- NOTE_OFF_VELOCITY, 7'h40, velocity byte sent with note-off.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- msg_valid  in  1  single-cycle pulse from buffer; other msg_* inputs valid in the same cycle
- msg_note_on  in  1  1 = note-on, 0 = note-off
- msg_note  in  4  note within octave, 0..11 legal
- msg_octave  in  2  octave 0..3
- msg_channel  in  4  MIDI channel 0..15
- msg_ack  out  1  single-cycle pulse: message consumed
- tx_data  out  8  byte to UART
- tx_valid  out  1  byte offered
- tx_ready  in  1  UART accepts byte; transfer when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- note_error  out  1  single-cycle pulse: illegal msg_note
- overrun  out  1  single-cycle pulse: msg_valid while not IDLE

Behaviour:
- One clock domain. reset_n is asynchronous active-low.
- Reset values:
  - state = IDLE
  - tx_valid, msg_ack, note_error, overrun, busy = 0
  - tx_data = 8'h00
  - latched fields = 0
  - running-status register invalid
- States: IDLE, STATUS, NOTE, VEL, ACK.
- IDLE:
  - msg_valid with msg_note ≤ 11 → latch all fields, go to STATUS.
  - msg_valid with msg_note ≥ 12 → note_error pulse next cycle, go to ACK; no bytes sent.
- Computed bytes:
  - status = {1'b1, msg_note_on ? 3'b001 : 3'b000, channel}, i.e. 0x9c for note-on, 0x8c for note-off.
  - note = BASE_NOTE + octave*12 + note, 7-bit unsigned, MSB forced 0.
  - velocity = NOTE_ON_VELOCITY or NOTE_OFF_VELOCITY.
- Registered outputs: tx_valid rises the cycle after msg_valid (latency 1) with tx_data = status.
- STATUS/NOTE/VEL:
  - tx_valid held high, tx_data stable, until tx_ready is sampled high.
  - Then advance STATUS→NOTE→VEL→ACK.
  - Next byte is presented the following cycle: tx_valid stays high, tx_data changes, no bubble.
  - Leaving VEL drops tx_valid.
- Backpressure: tx_ready held low indefinitely stalls in place. No timeout.
- ACK: msg_ack = 1 for exactly one cycle, then IDLE.
  - Minimum msg_valid-to-msg_ack is 4 cycles with tx_ready tied high.
  - Rejected note: msg_ack occurs 2 cycles after msg_valid.
- msg_valid in any state other than IDLE:
  - Event dropped; overrun pulses the next cycle.
  - Current message is unaffected.
  - Not expected with a well-behaved buffer, which waits for ack.
- msg_valid in the ACK cycle is also an overrun. The buffer cannot legally re-offer sooner than 1 cycle after seeing ack.
- tx_ready while tx_valid = 0 is ignored.
- Reset asserted mid-message: immediate return to IDLE, tx_valid drops asynchronously, partial message abandoned, no ack. The buffer is reset by the same reset.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - Sequencer keeps last_status plus a valid bit, set when a status byte is transferred.
  - If a new message's status equals last_status and the bit is valid, STATUS is skipped: IDLE→NOTE directly, 2 bytes sent, min latency msg_valid-to-msg_ack = 3 cycles.
  - Valid bit cleared by reset only.
  - A rejected note does not alter it.
- Undefined: status byte always sent; no last_status storage.

Test Plan:
- Note-on: msg_valid, ch 2, note 0, octave 1, tx_ready = 1 → bytes 0x92, 0x3C, 0x64 on consecutive cycles starting 1 cycle after msg_valid; msg_ack 4 cycles after msg_valid.
- Note-off: ch 15, note 11, octave 3 → bytes 0x8F, 0x5F, 0x40; one msg_ack; busy high from cycle +1 through ACK.
- Backpressure: tx_ready low 5 cycles during NOTE → tx_data held at 0x3C with tx_valid high, no byte skipped or repeated, ack delayed exactly 5 cycles.
- Illegal note 13 → note_error pulse, no tx_valid, msg_ack 2 cycles after msg_valid; second msg_valid during STATUS → overrun pulse, first message completes intact.
- Reset asserted during VEL → tx_valid low immediately, no msg_ack. After release, new note-on sends full 3 bytes, including status when MIDI_RUNNING_STATUS_EN is defined.
- With MIDI_RUNNING_STATUS_EN: two note-ons on ch 0 → first 0x90, 0x3C, 0x64; second 0x3E, 0x64 only. A following note-off on ch 0 resends 0x80.
